// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a valid/ready command into one APB SETUP/ACCESS transfer
// and reports completion, slave error or PREADY timeout as a single-cycle response.
module apb_master_bridge #(
   parameter int WDATA   = 8,
   parameter int WADDR   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic             i_PCLK,
   input  logic             i_PRESET,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic             i_cmd_write,
   input  logic [WADDR-1:0] i_cmd_addr,
   input  logic [WDATA-1:0] i_cmd_wdata,
   output logic             o_rsp_valid,
   output logic [WDATA-1:0] o_rsp_rdata,
   output logic             o_rsp_err,
   output logic             o_rsp_timeout,
   output logic             o_PSELx,
   output logic             o_PENABLE,
   output logic             o_PWRITE,
   output logic [WADDR-1:0] o_PADDR,
   output logic [WDATA-1:0] o_PWDATA,
   input  logic             i_PREADY,
   input  logic             i_PSLVERR,
   input  logic [WDATA-1:0] i_PRDATA
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   // counter value seen on the edge that would bring it to TIMEOUT
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t           state, state_nx;
   logic [7:0]       wait_cnt, wait_cnt_nx;
   logic             cmd_ready_nx, rsp_valid_nx, rsp_err_nx, rsp_timeout_nx;
   logic             psel_nx, penable_nx, pwrite_nx;
   logic [WDATA-1:0] rsp_rdata_nx, pwdata_nx;
   logic [WADDR-1:0] paddr_nx;

   always_comb begin
      state_nx       = state;
      wait_cnt_nx    = wait_cnt;
      rsp_valid_nx   = 1'b0;
      rsp_rdata_nx   = o_rsp_rdata;
      rsp_err_nx     = o_rsp_err;
      rsp_timeout_nx = o_rsp_timeout;
      psel_nx        = o_PSELx;
      penable_nx     = o_PENABLE;
      pwrite_nx      = o_PWRITE;
      paddr_nx       = o_PADDR;
      pwdata_nx      = o_PWDATA;
      case (state)
         IDLE: begin
            if (i_cmd_valid && o_cmd_ready) begin
               state_nx   = SETUP;
               psel_nx    = 1'b1;
               penable_nx = 1'b0;
               pwrite_nx  = i_cmd_write;
               paddr_nx   = i_cmd_addr;
               pwdata_nx  = i_cmd_wdata;
            end
         end
         SETUP: begin
            state_nx    = ACCESS;
            penable_nx  = 1'b1;
            wait_cnt_nx = '0;
         end
         ACCESS: begin
            // PREADY wins over a timeout on the same edge
            if (i_PREADY) begin
               state_nx       = IDLE;
               psel_nx        = 1'b0;
               penable_nx     = 1'b0;
               rsp_valid_nx   = 1'b1;
               rsp_err_nx     = i_PSLVERR;
               rsp_timeout_nx = 1'b0;
               rsp_rdata_nx   = o_PWRITE ? '0 : i_PRDATA;
            end else begin
               wait_cnt_nx = wait_cnt + 8'd1;
               if (wait_cnt == WAIT_LAST) begin
                  state_nx       = IDLE;
                  psel_nx        = 1'b0;
                  penable_nx     = 1'b0;
                  rsp_valid_nx   = 1'b1;
                  rsp_err_nx     = 1'b1;
                  rsp_timeout_nx = 1'b1;
                  rsp_rdata_nx   = '0;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
      cmd_ready_nx = (state_nx == IDLE);
   end

   always_ff @(posedge i_PCLK) begin
      if (i_PRESET) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         o_cmd_ready   <= 1'b0;
         o_rsp_valid   <= 1'b0;
         o_rsp_rdata   <= '0;
         o_rsp_err     <= 1'b0;
         o_rsp_timeout <= 1'b0;
         o_PSELx       <= 1'b0;
         o_PENABLE     <= 1'b0;
         o_PWRITE      <= 1'b0;
         o_PADDR       <= '0;
         o_PWDATA      <= '0;
      end else begin
         state         <= state_nx;
         wait_cnt      <= wait_cnt_nx;
         o_cmd_ready   <= cmd_ready_nx;
         o_rsp_valid   <= rsp_valid_nx;
         o_rsp_rdata   <= rsp_rdata_nx;
         o_rsp_err     <= rsp_err_nx;
         o_rsp_timeout <= rsp_timeout_nx;
         o_PSELx       <= psel_nx;
         o_PENABLE     <= penable_nx;
         o_PWRITE      <= pwrite_nx;
         o_PADDR       <= paddr_nx;
         o_PWDATA      <= pwdata_nx;
      end
   end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameters SHALL be: WDATA, default 8, data width; WADDR, default 8, address width; TIMEOUT, default 16, max ACCESS cycles waited for PREADY (range 2..255).
REQ-002 i_PCLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 i_PRESET  in  1  reset, synchronous, active-high.
REQ-004 i_cmd_valid  in  1  requester presents a command.
REQ-005 o_cmd_ready  out  1  bridge can accept a command this cycle.
REQ-006 i_cmd_write  in  1  1 = write, 0 = read.
REQ-007 i_cmd_addr  in  WADDR  target address; i_cmd_wdata  in  WDATA  write data.
REQ-008 o_rsp_valid  out  1  one-cycle response pulse.
REQ-009 o_rsp_rdata  out  WDATA  read data; o_rsp_err  out  1  error; o_rsp_timeout  out  1  timeout abort.
REQ-010 o_PSELx, o_PENABLE, o_PWRITE  out  1 each  APB control.
REQ-011 o_PADDR  out  WADDR; o_PWDATA  out  WDATA  APB address and write data.
REQ-012 i_PREADY, i_PSLVERR  in  1 each; i_PRDATA  in  WDATA  APB slave response.

Function
REQ-013 The FSM SHALL have states IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-014 o_cmd_ready SHALL be 1 only in IDLE; a command is accepted on an edge where i_cmd_valid and o_cmd_ready are both 1.
REQ-015 On acceptance, write/addr/wdata SHALL be captured into o_PWRITE/o_PADDR/o_PWDATA and the FSM SHALL enter SETUP with o_PSELx=1, o_PENABLE=0.
REQ-016 SETUP SHALL last exactly one cycle, then enter ACCESS with o_PSELx=1, o_PENABLE=1.
REQ-017 o_PADDR, o_PWRITE and o_PWDATA SHALL remain stable from SETUP through the end of ACCESS, and SHALL hold their last values in IDLE.
REQ-018 In ACCESS, an edge with i_PREADY=1 SHALL complete the transfer:
- next cycle: IDLE, o_PSELx=0, o_PENABLE=0, o_rsp_valid=1;
- o_rsp_err = sampled i_PSLVERR; o_rsp_timeout=0;
- o_rsp_rdata = sampled i_PRDATA for reads; 0 for writes.
REQ-019 Wait counter:
- cleared on entry to ACCESS;
- incremented on each ACCESS edge with i_PREADY=0;
- on the edge where it reaches TIMEOUT, the FSM SHALL abort to IDLE with o_PSELx=0, o_PENABLE=0, and pulse o_rsp_valid with o_rsp_err=1, o_rsp_timeout=1, o_rsp_rdata=0.
REQ-020 i_PREADY=1 on the same edge the counter would reach TIMEOUT SHALL be treated as normal completion (REQ-018), not timeout.
REQ-021 o_rsp_valid SHALL be high exactly one cycle per accepted command, with no backpressure; o_rsp_rdata/err/timeout SHALL hold their values until the next response.
REQ-022 Back-to-back commands SHALL have at least one IDLE cycle (o_PSELx=0) between transfers; minimum transfer time is 3 cycles from acceptance to response pulse.
REQ-023 i_PSLVERR and i_PRDATA SHALL be ignored except on the completing edge in ACCESS.
REQ-024 i_cmd_* inputs SHALL be ignored outside acceptance edges.

Reset
REQ-025 While i_PRESET=1 at an edge, the next state SHALL be IDLE with all outputs 0, except o_cmd_ready=1 one cycle after reset deasserts.
REQ-026 Reset in SETUP or ACCESS SHALL abort the transfer with no o_rsp_valid pulse, and SHALL clear the wait counter.

Verification
REQ-027 Write with a zero-wait slave (PREADY=1 in ACCESS), addr 0x10, data 0xA5 -> SETUP 1 cycle, ACCESS 1 cycle, PADDR=0x10, PWDATA=0xA5, PWRITE=1 throughout; then rsp_valid pulse with err=0, rdata=0x00.
REQ-028 Slave with one-cycle registered PREADY (asserted the cycle after it sees PSEL&PENABLE), read 0x10 returning 0xA5 -> ACCESS lasts 2 cycles; rsp_rdata=0xA5, err=0.
REQ-029 i_PREADY held at 0, TIMEOUT=16 -> abort after exactly 16 ACCESS cycles; rsp_valid=1, err=1, timeout=1, rdata=0; PSEL=0 the next cycle.
REQ-030 i_PSLVERR=1 with i_PREADY=1 on the completing edge of a read returning 0x3C -> rsp err=1, timeout=0, rdata=0x3C.
REQ-031 i_cmd_valid held high for two commands -> exactly 2 acceptances, one IDLE cycle with PSEL=0 between transfers, 2 response pulses in order.
REQ-032 i_PRESET asserted in the second ACCESS cycle -> next cycle all outputs 0 and no rsp_valid pulse; a command issued after reset completes normally.
